// File: rtl/vigna_bus_arbiter.sv
// vigna_bus_arbiter: merges the core's instruction and data ports onto one shared memory bus.
// Define VIGNA_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the data port wins ties.
module vigna_bus_arbiter #(
    parameter bit RESET_LAST_D = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    output logic [31:0] d_rdata,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    input  logic [31:0] m_rdata,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        busy,
    output logic        grant_d
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        last_d_q, last_d_d;
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;
    logic        pick_d;

`ifdef VIGNA_ARB_ROUND_ROBIN_EN
    assign pick_d = d_valid && (!i_valid || !last_d_q);
`else
    assign pick_d = d_valid;
`endif

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        if (state_q == IDLE) begin
            if (i_valid || d_valid) begin
                state_d   = pick_d ? GNT_D : GNT_I;
                last_d_d  = pick_d;
                m_valid_d = 1'b1;
                m_addr_d  = pick_d ? d_addr : i_addr;
                m_wdata_d = pick_d ? d_wdata : i_wdata;
                m_wstrb_d = pick_d ? d_wstrb : i_wstrb;
            end
        end else if (m_ready) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            last_d_q  <= RESET_LAST_D;
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
        end
    end

    // Responses pass straight through to whichever port holds the grant.
    assign i_ready = (state_q == GNT_I) && m_ready;
    assign d_ready = (state_q == GNT_D) && m_ready;
    assign i_rdata = (state_q == GNT_I) ? m_rdata : 32'd0;
    assign d_rdata = (state_q == GNT_D) ? m_rdata : 32'd0;
    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign busy    = (state_q == GNT_I) || (state_q == GNT_D);
    assign grant_d = (state_q == GNT_D);
endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// tb_vigna_bus_arbiter: directed plan plus randomized traffic against a transaction-level owner model.
module tb_vigna_bus_arbiter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_valid = 1'b0, d_valid = 1'b0, m_ready = 1'b0;
    logic        i_ready, d_ready, m_valid, busy, grant_d;
    logic [31:0] i_addr = '0, i_wdata = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  i_wstrb = '0, d_wstrb = '0, m_wstrb;

    always #5 clk = ~clk;

    vigna_bus_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_rdata(d_rdata),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_rdata(m_rdata),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .busy(busy), .grant_d(grant_d)
    );

    int checks = 0;
    int errors = 0;
    // Model: who owns the bus (0 nobody, 1 i-port, 2 d-port), who won last, latched request.
    int          own = 0;
    bit          ld = 1'b1;
    logic [31:0] ea = '0, ew = '0;
    logic [3:0]  es = '0;
    int          served[$];

    task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task sample();
        @(negedge clk);
        chk("m_valid", 32'(m_valid), 32'(own != 0));
        chk("busy", 32'(busy), 32'(own != 0));
        chk("grant_d", 32'(grant_d), 32'(own == 2));
        chk("m_addr", m_addr, ea);
        chk("m_wdata", m_wdata, ew);
        chk("m_wstrb", 32'(m_wstrb), 32'(es));
        chk("i_ready", 32'(i_ready), 32'(own == 1 && m_ready));
        chk("d_ready", 32'(d_ready), 32'(own == 2 && m_ready));
        chk("i_rdata", i_rdata, own == 1 ? m_rdata : 32'd0);
        chk("d_rdata", d_rdata, own == 2 ? m_rdata : 32'd0);
    endtask

    task tick();
        bit wd;
        if (own != 0 && m_ready) served.push_back(own);
        if (!resetn) begin
            own = 0; ld = 1'b1; ea = '0; ew = '0; es = '0;
        end else if (own == 0) begin
            if (i_valid || d_valid) begin
                if (!i_valid) wd = 1'b1;
                else if (!d_valid) wd = 1'b0;
`ifdef VIGNA_ARB_ROUND_ROBIN_EN
                else wd = !ld;
`else
                else wd = 1'b1;
`endif
                own = wd ? 2 : 1;
                ld  = wd;
                ea  = wd ? d_addr : i_addr;
                ew  = wd ? d_wdata : i_wdata;
                es  = wd ? d_wstrb : i_wstrb;
            end
        end else if (m_ready) begin
            own = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task cycle();
        sample();
        tick();
    endtask

    initial begin
        int n;
        // Reset hold with both requesters active
        resetn = 1'b0; i_valid = 1'b1; d_valid = 1'b1; m_ready = 1'b1;
        repeat (3) cycle();
        sample();
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_iready", 32'(i_ready), 32'd0);
        chk("rst_dready", 32'(d_ready), 32'd0);
        tick();
        resetn = 1'b1; i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
        cycle();

        // Single fetch with a two-cycle slave wait
        i_valid = 1'b1; i_addr = 32'h10;
        cycle();
        sample();
        chk("fetch_addr", m_addr, 32'h10);
        chk("fetch_wstrb", 32'(m_wstrb), 32'd0);
        tick();
        cycle();
        m_ready = 1'b1; m_rdata = 32'h13;
        sample();
        chk("fetch_ready", 32'(i_ready), 32'd1);
        chk("fetch_rdata", i_rdata, 32'h13);
        chk("fetch_dready", 32'(d_ready), 32'd0);
        tick();
        i_valid = 1'b0; m_ready = 1'b0;
        sample();
        chk("fetch_pulse_end", 32'(i_ready), 32'd0);
        tick();

        // Single store
        d_valid = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        cycle();
        sample();
        chk("store_addr", m_addr, 32'h100);
        chk("store_wdata", m_wdata, 32'hDEADBEEF);
        chk("store_wstrb", 32'(m_wstrb), 32'h3);
        chk("store_grant_d", 32'(grant_d), 32'd1);
        tick();
        m_ready = 1'b1;
        sample();
        chk("store_ready", 32'(d_ready), 32'd1);
        tick();
        d_valid = 1'b0; m_ready = 1'b0;
        sample();
        chk("store_hold_addr", m_addr, 32'h100);
        tick();

        // Ties from a fresh reset
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        served.delete();
        i_valid = 1'b1; d_valid = 1'b1; i_addr = 32'h200; d_addr = 32'h300;
`ifdef VIGNA_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 40 && served.size() < 4; k++) begin
            m_ready = (own != 0);
            cycle();
        end
        chk("rr_count", 32'(served.size()), 32'd4);
        if (served.size() == 4) begin
            chk("rr_0", 32'(served[0]), 32'd1);
            chk("rr_1", 32'(served[1]), 32'd2);
            chk("rr_2", 32'(served[2]), 32'd1);
            chk("rr_3", 32'(served[3]), 32'd2);
        end
`else
        for (int k = 0; k < 40 && served.size() < 2; k++) begin
            m_ready = (own != 0);
            n = served.size();
            cycle();
            if (served.size() > n) begin
                if (served[n] == 1) i_valid = 1'b0;
                else d_valid = 1'b0;
            end
        end
        chk("fp_count", 32'(served.size()), 32'd2);
        if (served.size() == 2) begin
            chk("fp_first_d", 32'(served[0]), 32'd2);
            chk("fp_then_i", 32'(served[1]), 32'd1);
        end
`endif
        i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
        cycle();

        // Reset in the middle of a data transaction
        d_valid = 1'b1; d_addr = 32'h440;
        cycle();
        sample();
        chk("mid_grant_d", 32'(grant_d), 32'd1);
        tick();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1; d_valid = 1'b0; m_ready = 1'b1;
        sample();
        chk("mid_mvalid", 32'(m_valid), 32'd0);
        chk("mid_dready", 32'(d_ready), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        tick();
        m_ready = 1'b0;
        cycle();

        // Randomized traffic, fields re-randomized every cycle to prove grant-time sampling
        for (int k = 0; k < 3000; k++) begin
            if (!i_valid && $urandom_range(0, 2) == 0) i_valid = 1'b1;
            if (!d_valid && $urandom_range(0, 2) == 0) d_valid = 1'b1;
            if ($urandom_range(0, 99) == 0) i_valid = 1'b0;
            if ($urandom_range(0, 99) == 0) d_valid = 1'b0;
            i_addr  = $urandom;
            i_wdata = ($urandom_range(0, 9) == 0) ? $urandom : 32'd0;
            i_wstrb = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
            m_rdata = $urandom;
            m_ready = (own != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            resetn  = ($urandom_range(0, 79) != 0);
            n = served.size();
            cycle();
            if (served.size() > n) begin
                if (served[n] == 1) i_valid = 1'b0;
                else d_valid = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vigna_bus_arbiter.md
# vigna_bus_arbiter

Two-master, one-slave arbiter that merges the vigna core's instruction port and data port onto one shared memory bus. The core can issue a fetch while a load or store is in flight, so both ports may request together. The arbiter serialises them, holding one grant until the slave completes the transaction. It sits between the core and a single-ported memory or interconnect.

## Interface
- `RESET_LAST_D`, default 1: value of the last-grant register after reset. 1 means the instruction port wins the first tie under round-robin.
- `clk` input 1: clock.
- `resetn` input 1: reset, synchronous, active-low.
- `i_valid` input 1: instruction-port request.
- `i_ready` output 1: instruction-port completion pulse.
- `i_addr` input 32: instruction-port address.
- `i_rdata` output 32: instruction-port read data.
- `i_wdata` input 32: instruction-port write data (normally 0).
- `i_wstrb` input 4: instruction-port write strobes (normally 0).
- `d_valid` input 1: data-port request.
- `d_ready` output 1: data-port completion pulse.
- `d_addr` input 32: data-port address.
- `d_rdata` output 32: data-port read data.
- `d_wdata` input 32: data-port write data.
- `d_wstrb` input 4: data-port write strobes; 0 means read.
- `m_valid` output 1: shared-bus request (registered).
- `m_ready` input 1: shared-bus completion.
- `m_addr` output 32: shared-bus address (registered).
- `m_rdata` input 32: shared-bus read data.
- `m_wdata` output 32: shared-bus write data (registered).
- `m_wstrb` output 4: shared-bus write strobes (registered).
- `busy` output 1: high in GNT_I and GNT_D.
- `grant_d` output 1: high only in GNT_D.

## Operation
- Bus protocol on all ports:
  - Requester raises `valid` and holds it, with address, data and strobes stable, until it sees `ready`.
  - `ready` is high for exactly one cycle. `rdata` is valid in that cycle.
- States are IDLE, GNT_I and GNT_D.
- IDLE:
  - Only `i_valid`: latch the i-port fields into the m-port registers, set `m_valid` to 1, go to GNT_I, set `last_d` to 0.
  - Only `d_valid`: latch the d-port fields, set `m_valid` to 1, go to GNT_D, set `last_d` to 1.
  - Both valid: the winner is decided by the configuration (see Configuration).
  - Neither valid: stay in IDLE.
- GNT_x:
  - `x_ready` = `m_ready` (combinational). `x_rdata` = `m_rdata` (combinational).
  - The other port's `ready` is 0 and its `rdata` is 0.
  - When `m_ready` is high: clear `m_valid` and return to IDLE.
- `m_ready` is ignored in IDLE. No `ready` pulse is forwarded from IDLE.
- Requester fields are sampled only at grant. Changes after grant are ignored.
- If the granted requester drops `valid` mid-transaction (a protocol violation), the transaction still completes and the `ready` pulse is still forwarded.
- `m_addr`, `m_wdata` and `m_wstrb` hold their last values after completion. They are not cleared.

## Timing
- Reset values:
  - `m_valid`=0, `m_addr`=0, `m_wdata`=0, `m_wstrb`=0.
  - State = IDLE, `last_d`=`RESET_LAST_D`.
  - `i_ready`=`d_ready`=0, `i_rdata`=`d_rdata`=0, `busy`=0, `grant_d`=0.
- Request latency: `valid` sampled in IDLE at edge N gives `m_valid`=1 from edge N.
- Response latency: zero cycles. `m_ready` in cycle C appears as `x_ready` in cycle C.
- Minimum transaction is 2 cycles: grant edge, then `m_ready` cycle.
- After a completion the arbiter spends at least one cycle in IDLE before the next grant. The maximum issue rate is one transaction per 2 cycles plus the slave wait.
- A request that arrives during a grant is held by its requester and arbitrated in the next IDLE cycle.
- Reset asserted mid-transaction: at the next edge the state is IDLE and `m_valid`=0. A late `m_ready` is ignored.
- The slave must not assert `m_ready` while `m_valid`=0. If it does, the arbiter ignores it.

## Configuration
- Macro `VIGNA_ARB_ROUND_ROBIN_EN`.
- Defined: on a tie in IDLE, the port not granted last wins (`last_d`=1 gives i-port, `last_d`=0 gives d-port). `last_d` updates on every grant.
- Undefined: fixed priority, and the data port always wins ties. `last_d` is still maintained but does not affect the choice.

## Test plan
- Reset hold: hold `resetn`=0 for 3 cycles with both valids high -> all outputs at their reset values, `m_valid`=0, no `ready` pulses.
- Single fetch: `i_valid`=1, `i_addr`=0x0000_0010; slave waits 2 cycles, then `m_ready`=1 with `m_rdata`=0x0000_0013 -> `m_addr`=0x10, `m_wstrb`=0, `i_ready` pulses one cycle with `i_rdata`=0x13, `d_ready` stays 0.
- Single store: `d_valid`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `d_wstrb`=4'b0011 -> m-port carries the same three values, `grant_d`=1, `d_ready` pulses once.
- Tie, fixed priority (macro off): both valid in the same cycle -> d-port served first, i-port granted after one IDLE cycle. Two `ready` pulses, d then i.
- Tie, round-robin (macro on): 4 back-to-back ties with both requesters re-asserting -> grant order I, D, I, D from reset.
- Reset mid-transaction: assert `resetn`=0 in GNT_D before `m_ready`, then `m_ready`=1 in the next cycle -> `m_valid`=0 after the edge, `d_ready` never pulses, state is IDLE.
